// File: rtl/uart_wb_burst_bridge.sv
// Byte-stream to Wishbone classic master bridge: host frames drive single or
// burst word accesses with auto-incrementing addresses; read data streams back MSB first.
module uart_wb_burst_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 30,
  parameter int MAX_BURST  = 255,
  parameter int WB_TIMEOUT = 1023,
  parameter int RX_TIMEOUT = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic                    wb_we,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH-1:0]   wb_dat_w,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [DATA_WIDTH-1:0]   wb_dat_r,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  output logic                    busy,
  output logic                    error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int WT_W  = $clog2(WB_TIMEOUT + 1);
  localparam int RT_W  = $clog2(RX_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;

  logic [2:0]            state;
  logic                  is_wr;
  logic                  rdy_en;
  logic                  err_q;
  logic [7:0]            cnt;
  logic [7:0]            byte_cnt;
  logic [23:0]           addr_sh;
  logic [ADDR_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0] shreg;
  logic [WT_W-1:0]       wb_tmr;
  logic [RT_W-1:0]       rx_tmr;

  logic rx_state, rx_fire, tx_fire, wb_to, wb_done, wb_fail, last_byte, rx_to;

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    if ({24'd0, len} > 32'(MAX_BURST)) return 8'(MAX_BURST);
    return len;
  endfunction

  assign rx_state  = (state == S_LEN) || (state == S_ADDR) || (state == S_WDATA);
  assign rx_ready  = rdy_en && ((state == S_IDLE) || rx_state);
  assign rx_fire   = rx_valid && rx_ready;
  assign tx_valid  = (state == S_RDATA);
  assign tx_fire   = tx_valid && tx_ready;
  assign tx_data   = shreg[DATA_WIDTH-1 -: 8];

  // Bus strobes are decoded from state so an async reset drops them immediately.
  assign wb_cyc    = (state == S_WB);
  assign wb_stb    = wb_cyc;
  assign wb_we     = wb_cyc && is_wr;
  assign wb_sel    = {BYTES{wb_cyc}};
  assign wb_adr    = adr;
  assign wb_dat_w  = shreg;
  assign busy      = (state != S_IDLE);
  assign error     = err_q;

  assign wb_to     = (wb_tmr == WT_W'(WB_TIMEOUT - 1));
  assign wb_done   = wb_ack || wb_err || wb_to;
  assign wb_fail   = wb_err || (wb_to && !wb_ack);
  assign last_byte = (byte_cnt == 8'(BYTES - 1));
  assign rx_to     = rx_state && !rx_fire && (rx_tmr == RT_W'(RX_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      is_wr    <= 1'b0;
      rdy_en   <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      byte_cnt <= '0;
      addr_sh  <= '0;
      adr      <= '0;
      shreg    <= '0;
      wb_tmr   <= '0;
      rx_tmr   <= '0;
    end else begin
      rdy_en <= 1'b1;
      rx_tmr <= (rx_state && !rx_fire) ? rx_tmr + RT_W'(1) : '0;
      wb_tmr <= (state == S_WB && !wb_done) ? wb_tmr + WT_W'(1) : '0;

      case (state)
        S_IDLE: begin
          if (rx_fire && (rx_data == 8'h01 || rx_data == 8'h02)) begin
            is_wr <= (rx_data == 8'h01);
            err_q <= 1'b0;
            state <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_fire) begin
            cnt      <= clamp_len(rx_data);
            byte_cnt <= '0;
            state    <= S_ADDR;
          end else if (rx_to) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_sh  <= {addr_sh[15:0], rx_data};
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'd3) begin
              // Upper address bits beyond ADDR_WIDTH are intentionally dropped.
              adr      <= ADDR_WIDTH'({addr_sh, rx_data});
              byte_cnt <= '0;
              if (cnt == 8'd0)  state <= S_IDLE;
              else if (is_wr)   state <= S_WDATA;
              else              state <= S_WB;
            end
          end else if (rx_to) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            shreg <= (shreg << 8) | DATA_WIDTH'(rx_data);
            if (last_byte) begin
              byte_cnt <= '0;
              state    <= S_WB;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end else if (rx_to) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_WB: begin
          if (wb_done) begin
            if (wb_fail) err_q <= 1'b1;
            if (is_wr) begin
              cnt   <= cnt - 8'd1;
              adr   <= adr + ADDR_WIDTH'(1);
              state <= (cnt == 8'd1) ? S_IDLE : S_WDATA;
            end else begin
              shreg    <= wb_fail ? '0 : wb_dat_r;
              byte_cnt <= '0;
              state    <= S_RDATA;
            end
          end
        end
        S_RDATA: begin
          if (tx_fire) begin
            shreg <= shreg << 8;
            if (last_byte) begin
              byte_cnt <= '0;
              cnt      <= cnt - 8'd1;
              adr      <= adr + ADDR_WIDTH'(1);
              state    <= (cnt == 8'd1) ? S_IDLE : S_WB;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_burst_bridge.sv
// Testbench for uart_wb_burst_bridge: directed frames plus randomized bursts
// compared against a word-level reference model of the frame protocol.
module tb_uart_wb_burst_bridge;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;
  logic        busy, error;

  always #5 clk = ~clk;

  uart_wb_burst_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(30), .MAX_BURST(MB), .WB_TIMEOUT(1023), .RX_TIMEOUT(65535)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err), .busy(busy), .error(error)
  );

  int checks = 0;
  int errors = 0;

  // Environment state: memory contents, error-responding addresses, bus/tx logs.
  logic [31:0] mem [logic [29:0]];
  bit          err_set [logic [29:0]];
  int          slave_mode = 0;
  int          ack_dly_max = 0;
  logic [29:0] log_adr[$];
  logic        log_we[$];
  logic [31:0] log_dat[$];
  int          log_txc[$];
  int          log_bad_sel = 0;
  int          cyc_cycles = 0;
  logic [7:0]  txq[$];
  int          tx_total = 0;
  int          tx_base = 0;
  int          tx_mode = 0;
  int          tx_hold = 0;
  int          stall_viol = 0;
  int          stall_cycles = 0;

  // Reference expectations.
  logic [29:0] exp_adr[$];
  logic        exp_we[$];
  logic [31:0] exp_dat[$];
  logic [7:0]  exp_tx[$];
  bit          exp_err;

  function automatic logic [31:0] rd_mem(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, 2'b01} ^ 32'hC3A5_0F96;
  endfunction

  // Wishbone slave: logs each cycle and answers after a random delay.
  initial begin
    int wcnt = 0;
    int dly = 0;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = $urandom();
      if (wb_cyc) begin
        cyc_cycles++;
        if (wb_sel !== 4'hF || wb_stb !== 1'b1) log_bad_sel++;
        if (wcnt == 0) begin
          log_adr.push_back(wb_adr); log_we.push_back(wb_we);
          log_dat.push_back(wb_dat_w); log_txc.push_back(tx_total);
          dly = $urandom_range(ack_dly_max, 0);
        end
        if (slave_mode == 0 && wcnt == dly) begin
          if (err_set.exists(wb_adr)) begin
            wb_err = 1'b1; wb_ack = 1'($urandom_range(1, 0)); wb_dat_r = ~rd_mem(wb_adr);
          end else begin
            wb_ack = 1'b1; wb_dat_r = rd_mem(wb_adr);
          end
        end
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
  end

  // TX sink with optional backpressure and a hold-stability monitor.
  initial begin
    logic [7:0] prev_d = '0;
    bit prev_stall = 0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== prev_d)) stall_viol++;
      if (tx_hold > 0) begin tx_ready = 1'b0; tx_hold--; end
      else if (tx_mode == 1) tx_ready = ($urandom_range(2, 0) != 0);
      else tx_ready = 1'b1;
      if (tx_valid && tx_ready) begin txq.push_back(tx_data); tx_total++; end
      prev_stall = tx_valid && !tx_ready;
      if (prev_stall) stall_cycles++;
      prev_d = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b; rx_valid = 1'b1;
    while (!rx_ready && n < 5000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 5000) begin errors++; $display("FAIL rx_accept got rx_ready=0 expected 1 within 5000 cycles"); end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [31:0] addr, input logic [31:0] wd[$], input int gap);
    logic [7:0] b[$];
    b.push_back(cmd); b.push_back(len);
    for (int i = 3; i >= 0; i--) b.push_back(addr[i*8 +: 8]);
    foreach (wd[i]) for (int k = 3; k >= 0; k--) b.push_back(wd[i][k*8 +: 8]);
    foreach (b[i]) begin
      repeat ($urandom_range(gap, 0)) @(negedge clk);
      send_byte(b[i]);
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    ok = !busy;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    log_adr.delete(); log_we.delete(); log_dat.delete(); log_txc.delete();
    txq.delete(); log_bad_sel = 0; cyc_cycles = 0; stall_viol = 0; stall_cycles = 0;
    tx_base = tx_total;
  endtask

  // Word-level model: clamped burst, wrapping word addresses, err words read as 0.
  task automatic predict(input logic [7:0] cmd, input logic [7:0] len,
                         input logic [31:0] addr, input logic [31:0] wd[$]);
    int n = (int'(len) > MB) ? MB : int'(len);
    exp_adr.delete(); exp_we.delete(); exp_dat.delete(); exp_tx.delete(); exp_err = 0;
    for (int i = 0; i < n; i++) begin
      logic [29:0] a = addr[29:0] + 30'(i);
      logic [31:0] v;
      exp_adr.push_back(a); exp_we.push_back(cmd == 8'h01);
      if (err_set.exists(a)) exp_err = 1;
      if (cmd == 8'h01) begin
        exp_dat.push_back(wd[i]);
        if (!err_set.exists(a)) mem[a] = wd[i];
      end else begin
        exp_dat.push_back('0);
        v = err_set.exists(a) ? 32'h0 : rd_mem(a);
        for (int k = 3; k >= 0; k--) exp_tx.push_back(v[k*8 +: 8]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rx_valid = 1'b0; rx_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready, tx_valid, tx_data, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel, busy, error} !== '0) begin
      errors++; $display("FAIL reset_outputs got cyc=%b rdy=%b busy=%b adr=%h expected all 0", wb_cyc, rx_ready, busy, wb_adr);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b expected 0", rx_ready); end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset got rx_ready=%b busy=%b expected 1 0", rx_ready, busy);
    end
  endtask

  task automatic test_write();
    logic [31:0] wd[$];
    bit ok;
    wd.push_back(32'hDEADBEEF);
    slave_mode = 0; ack_dly_max = 2; tx_mode = 0;
    clear_logs();
    send_frame(8'h01, 8'h01, 32'h0000_2403, wd, 1);
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_idle got busy=1 expected 0"); end
    checks++;
    if (log_adr.size() !== 1) begin errors++; $display("FAIL wr_count got %0d expected 1", log_adr.size()); end
    else begin
      checks++;
      if (log_adr[0] !== 30'h2403 || log_we[0] !== 1'b1 || log_dat[0] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL wr_txn got adr=%h we=%b dat=%h expected 2403 1 deadbeef", log_adr[0], log_we[0], log_dat[0]);
      end
    end
    checks++;
    if (log_bad_sel !== 0 || error !== 1'b0) begin
      errors++; $display("FAIL wr_sel_err got bad_sel=%0d error=%b expected 0 0", log_bad_sel, error);
    end
  endtask

  task automatic test_burst_read();
    logic [31:0] wd[$];
    logic [7:0] want[$];
    bit ok;
    mem[30'h10] = 32'h11111111; mem[30'h11] = 32'h22222222; mem[30'h12] = 32'h33333333;
    for (int w = 1; w <= 3; w++) for (int k = 0; k < 4; k++) want.push_back(8'(w * 8'h11));
    slave_mode = 0; ack_dly_max = 3; tx_mode = 0;
    clear_logs();
    send_frame(8'h02, 8'h03, 32'h0000_0010, wd, 0);
    wait_idle(500, ok);
    checks++;
    if (log_adr.size() !== 3) begin errors++; $display("FAIL rd_count got %0d expected 3", log_adr.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (log_adr[i] !== 30'(32'h10 + i) || log_we[i] !== 1'b0) begin
        errors++; $display("FAIL rd_adr%0d got %h we=%b expected %h 0", i, log_adr[i], log_we[i], 32'h10 + i);
      end
    end
    checks++;
    if (txq != want) begin errors++; $display("FAIL rd_bytes got %p expected %p", txq, want); end
  endtask

  task automatic test_backpressure();
    logic [31:0] wd[$];
    logic [31:0] addr = $urandom();
    bit ok;
    int n = 0;
    slave_mode = 0; ack_dly_max = 0; tx_mode = 0; err_set.delete();
    predict(8'h02, 8'h02, addr, wd);
    clear_logs();
    send_frame(8'h02, 8'h02, addr, wd, 0);
    while (tx_total - tx_base < 2 && n < 2000) begin @(negedge clk); n++; end
    tx_hold = 5;
    wait_idle(500, ok);
    checks++;
    if (stall_viol !== 0 || stall_cycles < 5) begin
      errors++; $display("FAIL bp_stable got viol=%0d stalls=%0d expected 0 >=5", stall_viol, stall_cycles);
    end
    checks++;
    if (txq != exp_tx) begin errors++; $display("FAIL bp_bytes got %p expected %p", txq, exp_tx); end
    checks++;
    if (log_txc.size() !== 2 || log_txc[1] - tx_base !== 4) begin
      errors++; $display("FAIL bp_order got txns=%0d second_at=%0d expected 2 4", log_txc.size(),
                         (log_txc.size() > 1) ? log_txc[1] - tx_base : -1);
    end
  endtask

  task automatic test_ack_timeout();
    logic [31:0] wd[$];
    bit ok;
    slave_mode = 1; tx_mode = 0;
    clear_logs();
    send_frame(8'h02, 8'h01, 32'h0, wd, 0);
    wait_idle(3000, ok);
    checks++;
    if (cyc_cycles !== 1023) begin errors++; $display("FAIL to_cyc_len got %0d expected 1023", cyc_cycles); end
    checks++;
    if (txq.size() !== 4 || txq[0] !== 8'h00 || txq[1] !== 8'h00 || txq[2] !== 8'h00 || txq[3] !== 8'h00) begin
      errors++; $display("FAIL to_bytes got %p expected 4 zero bytes", txq);
    end
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL to_error got %b expected 1", error); end
    slave_mode = 0;
    send_byte(8'h01);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL to_error_clear got %b expected 0", error); end
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    wait_idle(50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_len0_idle got busy=1 expected 0"); end
  endtask

  task automatic test_rx_timeout();
    logic [31:0] wd[$];
    bit ok;
    clear_logs();
    send_byte(8'h55);
    checks++;
    if (busy !== 1'b0 || error !== 1'b0) begin
      errors++; $display("FAIL garbage got busy=%b error=%b expected 0 0", busy, error);
    end
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    repeat (65000) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rxto_early got busy=%b expected 1", busy); end
    wait_idle(1000, ok);
    checks++;
    if (!ok || error !== 1'b1 || cyc_cycles !== 0) begin
      errors++; $display("FAIL rxto got busy=%b error=%b cyc=%0d expected 0 1 0", busy, error, cyc_cycles);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] wd[$];
    bit ok;
    int n = 0;
    slave_mode = 1;
    clear_logs();
    send_frame(8'h02, 8'h01, 32'h0000_0055, wd, 0);
    while (!wb_cyc && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (wb_cyc !== 1'b1) begin errors++; $display("FAIL ar_cyc_start got %b expected 1", wb_cyc); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rx_ready, tx_valid, tx_data, wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel, busy, error} !== '0) begin
      errors++; $display("FAIL ar_outputs got cyc=%b busy=%b adr=%h expected all 0", wb_cyc, busy, wb_adr);
    end
    @(negedge clk);
    rst_n = 1'b1; slave_mode = 0;
    @(negedge clk);
    clear_logs();
    send_frame(8'h01, 8'h00, 32'h0, wd, 0);
    wait_idle(50, ok);
    checks++;
    if (!ok || log_adr.size() !== 0 || error !== 1'b0) begin
      errors++; $display("FAIL ar_len0 got busy=%b txns=%0d error=%b expected 0 0 0", busy, log_adr.size(), error);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] wd[$];
    logic [31:0] none[$];
    bit ok;
    for (int i = 0; i < MB; i++) wd.push_back($urandom());
    slave_mode = 0; ack_dly_max = 1; tx_mode = 0; err_set.delete();
    predict(8'h01, 8'hFF, 32'h3FFF_FFFF, wd);
    clear_logs();
    send_frame(8'h01, 8'hFF, 32'h3FFF_FFFF, wd, 0);
    wait_idle(500, ok);
    checks++;
    if (log_adr.size() !== MB) begin errors++; $display("FAIL clamp_count got %0d expected %0d", log_adr.size(), MB); end
    else for (int i = 0; i < MB; i++) begin
      checks++;
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i] || log_we[i] !== 1'b1) begin
        errors++; $display("FAIL clamp_w%0d got %h/%h expected %h/%h", i, log_adr[i], log_dat[i], exp_adr[i], exp_dat[i]);
      end
    end
    predict(8'h02, 8'h02, 32'hFFFF_FFFF, none);
    clear_logs();
    send_frame(8'h02, 8'h02, 32'hFFFF_FFFF, none, 0);
    wait_idle(500, ok);
    checks++;
    if (log_adr.size() !== 2 || log_adr[0] !== 30'h3FFF_FFFF || log_adr[1] !== 30'h0) begin
      errors++; $display("FAIL wrap_adr got %p expected 3fffffff 0", log_adr);
    end
    checks++;
    if (txq != exp_tx) begin errors++; $display("FAIL wrap_bytes got %p expected %p", txq, exp_tx); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic [31:0] wd[$];
      logic [7:0]  cmd = ($urandom_range(1, 0) == 1) ? 8'h01 : 8'h02;
      logic [7:0]  len = 8'($urandom_range(6, 0));
      logic [31:0] addr = ($urandom_range(4, 0) == 0) ? 32'h3FFF_FFFE : $urandom();
      int          n;
      bit          ok;
      err_set.delete();
      if ($urandom_range(3, 0) == 0) err_set[addr[29:0] + 30'($urandom_range(3, 0))] = 1;
      ack_dly_max = $urandom_range(3, 0);
      tx_mode = $urandom_range(1, 0);
      n = (int'(len) > MB) ? MB : int'(len);
      if (cmd == 8'h01) for (int i = 0; i < n; i++) wd.push_back($urandom());
      predict(cmd, len, addr, wd);
      clear_logs();
      send_frame(cmd, len, addr, wd, 2);
      wait_idle(1000, ok);
      checks++;
      if (log_adr.size() !== exp_adr.size()) begin
        errors++; $display("FAIL rnd%0d_count got %0d expected %0d", it, log_adr.size(), exp_adr.size());
      end else for (int i = 0; i < exp_adr.size(); i++) begin
        checks++;
        if (log_adr[i] !== exp_adr[i] || log_we[i] !== exp_we[i] || (exp_we[i] && log_dat[i] !== exp_dat[i])
            || (!exp_we[i] && log_txc[i] - tx_base !== 4 * i)) begin
          errors++; $display("FAIL rnd%0d_txn%0d got %h/%b/%h expected %h/%b/%h", it, i,
                             log_adr[i], log_we[i], log_dat[i], exp_adr[i], exp_we[i], exp_dat[i]);
        end
      end
      checks++;
      if (txq != exp_tx) begin errors++; $display("FAIL rnd%0d_bytes got %p expected %p", it, txq, exp_tx); end
      checks++;
      if (error !== exp_err || stall_viol !== 0 || log_bad_sel !== 0 || !ok) begin
        errors++; $display("FAIL rnd%0d_status got err=%b viol=%0d sel=%0d idle=%b expected %b 0 0 1",
                           it, error, stall_viol, log_bad_sel, ok, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_burst_read();
    test_backpressure();
    test_ack_timeout();
    test_rx_timeout();
    test_async_reset();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
